magcmp_serial_scheduler: RTL and testbench

//  Shares one bit-serial magnitude-compare engine between two requesters.

---
 rtl/magcmp_pkg.sv | 23 ++
 rtl/rr_arbiter_2.sv | 22 ++
 rtl/magcmp_serial_scheduler.sv | 144 ++++++++++++++
 tb/tb_magcmp_serial_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/magcmp_pkg.sv
// Shared definitions for the bit-serial magnitude-compare scheduler.
//   MAGCMP_WIDTH : default operand width
//   state_e      : scheduler FSM states
//   SEL_LT/GT    : encoding of the requester's select bit
//   sel_result   : picks the reported relation from the lt/gt flags
package magcmp_pkg;

  localparam int MAGCMP_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic SEL_LT = 1'b0;
  localparam logic SEL_GT = 1'b1;

  function automatic logic sel_result(input logic sel, input logic lt, input logic gt);
    return (sel == SEL_GT) ? gt : lt;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant (purely combinational).
//   valid_i[1:0] : request lines
//   ptr_i        : requester that wins when both are valid
//   grant_o[1:0] : one-hot grant, zero when nobody requests
module rr_arbiter_2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // Single requester always wins; a tie is resolved by the pointer.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/magcmp_serial_scheduler.sv
// Shares one MSB-first bit-serial magnitude comparator between two requesters.
//   clk, reset               : rising-edge clock, synchronous active-high reset
//   reqN_valid/ready         : request handshake for requester N (0/1)
//   reqN_a/b/select          : operands and relation (0: a<b, 1: a>b)
//   rsp_valid/ready          : response handshake
//   rsp_id/out/eq            : requester id, selected relation, equality flag
//   busy                     : FSM is not idle
module magcmp_serial_scheduler
  import magcmp_pkg::*;
#(
  parameter int WIDTH = MAGCMP_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_select,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_select,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_out,
  output logic             rsp_eq,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sel_q, sel_d, id_q, id_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             rr_q, rr_d;
  logic             rsp_id_q, rsp_id_d, rsp_out_q, rsp_out_d, rsp_eq_q, rsp_eq_d;
  logic [1:0]       grant_s;
  logic             a_bit_s, b_bit_s;

  rr_arbiter_2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .ptr_i   (rr_q),
    .grant_o (grant_s)
  );

  assign a_bit_s = a_q[idx_q];
  assign b_bit_s = b_q[idx_q];

  // State, operand, counter, pointer and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      sel_q     <= 1'b0;
      id_q      <= 1'b0;
      idx_q     <= {IW{1'b0}};
      rr_q      <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_out_q <= 1'b0;
      rsp_eq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_eq_q  <= rsp_eq_d;
    end
  end

  // Next-state logic, accept handshake and compare step.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    id_d       = id_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    rsp_id_d   = rsp_id_q;
    rsp_out_d  = rsp_out_q;
    rsp_eq_d   = rsp_eq_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant_s[0];
        req1_ready = grant_s[1];
        if (grant_s != 2'b00) begin
          a_d     = grant_s[1] ? req1_a : req0_a;
          b_d     = grant_s[1] ? req1_b : req0_b;
          sel_d   = grant_s[1] ? req1_select : req0_select;
          id_d    = grant_s[1];
          idx_d   = IW'(WIDTH - 1);
          state_d = COMPARE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        // First differing bit from the top decides; a's bit is the gt flag.
        if (a_bit_s != b_bit_s) begin
          rsp_out_d = sel_result(sel_q, ~a_bit_s, a_bit_s);
          rsp_eq_d  = 1'b0;
          rsp_id_d  = id_q;
          state_d   = DONE;
        end else if (idx_q == {IW{1'b0}}) begin
          rsp_out_d = 1'b0;
          rsp_eq_d  = 1'b1;
          rsp_id_d  = id_q;
          state_d   = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        // The other requester gets priority on the next tie.
        if (rsp_ready) begin
          rr_d    = ~rsp_id_q;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_eq    = rsp_eq_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_magcmp_serial_scheduler.sv
// Directed self-checking bench for magcmp_serial_scheduler (WIDTH=3).
module tb_magcmp_serial_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_select;
  logic [2:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_select;
  logic [2:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_out, rsp_eq, busy;

  int checks = 0;
  int errors = 0;

  magcmp_serial_scheduler #(.WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_select(req0_select),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_select(req1_select),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_eq(rsp_eq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input logic id, input logic [2:0] a, input logic [2:0] b,
                         input logic sel, input logic v);
    if (id) begin
      req1_a = a; req1_b = b; req1_select = sel; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_select = sel; req0_valid = v;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic accept(input logic id, input string tag);
    int n = 0;
    #1;
    while (!rdy(id) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_ready"}, int'(rdy(id)), 1);
    chk({tag, "_other_ready"}, int'(rdy(~id)), 0);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until rsp_valid rises.
  task automatic wait_rsp(input int elat, input string tag);
    int lat = 0;
    #1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
  endtask

  task automatic complete(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_valid"}, int'(rsp_valid), 0);
  endtask

  task automatic serve(input logic id, input logic [2:0] a, input logic [2:0] b,
                       input logic sel, input logic eout, input logic eeq,
                       input int elat, input int stall, input string tag);
    set_req(id, a, b, sel, 1'b1);
    accept(id, tag);
    wait_rsp(elat, tag);
    chk({tag, "_out"}, int'(rsp_out), int'(eout));
    chk({tag, "_eq"}, int'(rsp_eq), int'(eeq));
    chk({tag, "_id"}, int'(rsp_id), int'(id));
    chk({tag, "_busy"}, int'(busy), 1);
    repeat (stall) @(posedge clk);
    #1;
    complete(tag);
  endtask

  initial begin
    logic       e_out, e_eq;
    int         e_lat;
    logic [2:0] x;
    reset = 1'b1; rsp_ready = 1'b0;
    set_req(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    set_req(1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_out", int'(rsp_out), 0);
    chk("rst_eq", int'(rsp_eq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 3: both valid straight after reset, pointer 0 picks requester 0
    set_req(1'b1, 3'b001, 3'b000, 1'b1, 1'b1);
    serve(1'b0, 3'b110, 3'b011, 1'b1, 1'b1, 1'b0, 1, 0, "t3_r0");
    serve(1'b1, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 3, 0, "t3_r1");
    set_req(1'b1, 3'b101, 3'b101, 1'b0, 1'b1);
    serve(1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1, 0, "t3_tie");
    serve(1'b1, 3'b101, 3'b101, 1'b0, 1'b0, 1'b1, 3, 0, "t3_r1b");

    // 1 and 2: basic compares
    serve(1'b0, 3'b101, 3'b101, 1'b0, 1'b0, 1'b1, 3, 0, "t1_eq");
    serve(1'b0, 3'b010, 3'b101, 1'b0, 1'b1, 1'b0, 1, 0, "t2_lt");
    serve(1'b0, 3'b010, 3'b101, 1'b1, 1'b0, 1'b0, 1, 0, "t2_gt");

    // 4: consumer stalls; requester 0 waits and must not see ready
    set_req(1'b1, 3'b111, 3'b000, 1'b0, 1'b1);
    accept(1'b1, "t4");
    wait_rsp(1, "t4");
    set_req(1'b0, 3'b011, 3'b011, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("t4_valid", int'(rsp_valid), 1);
      chk("t4_out", int'(rsp_out), 0);
      chk("t4_eq", int'(rsp_eq), 0);
      chk("t4_id", int'(rsp_id), 1);
      chk("t4_ready0", int'(req0_ready), 0);
      chk("t4_ready1", int'(req1_ready), 0);
      chk("t4_busy", int'(busy), 1);
    end
    #1;
    complete("t4");
    serve(1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 1'b1, 3, 0, "t4_r0");

    // 5: pointer is now 1; reset mid-compare drops the request and clears it
    set_req(1'b1, 3'b100, 3'b101, 1'b0, 1'b1);
    accept(1'b1, "t5");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("t5_no_rsp", int'(rsp_valid), 0);
    end
    #1;
    set_req(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
    set_req(1'b1, 3'b000, 3'b000, 1'b0, 1'b1);
    #1;
    chk("t5_ptr_ready0", int'(req0_ready), 1);
    chk("t5_ptr_ready1", int'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // 6: exhaustive against integer compare, random response stalls
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          e_eq  = (a == b);
          e_out = (s == 1) ? (a > b) : (a < b);
          x     = 3'(a ^ b);
          e_lat = x[2] ? 1 : (x[1] ? 2 : 3);
          serve(1'(a), 3'(a), 3'(b), 1'(s), e_out, e_eq, e_lat,
                int'($urandom_range(0, 2)), "t6");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
